// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Edge-detects the divider's pixel-clock level into a
// strobe on clk, advances the h/v counters on that strobe, then registers the decode.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_clk_in,
  input  logic          en,
  output logic          pix_stb,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_VIS    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic          pix_d_q, pix_d_d;
  logic          arm_q, arm_d;
  logic          upd_q, upd_d;
  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic          pix_stb_q, pix_stb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          stb;

  always_comb begin
    stb     = arm_q & pix_clk_in & ~pix_d_q & en;
    pix_d_d = pix_clk_in;
    arm_d   = 1'b1;
    upd_d   = stb;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (stb) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Decode is taken from the counters one cycle after they moved, so every
  // output (and pix_stb) changes together on the cycle after the strobe.
  always_comb begin
    pix_stb_d     = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    x_d           = x_q;
    y_d           = y_q;
    if (upd_q) begin
      pix_stb_d     = 1'b1;
      x_d           = h_cnt_q;
      y_d           = v_cnt_q;
      active_d      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_d_q       <= 1'b0;
      arm_q         <= 1'b0;
      upd_q         <= 1'b0;
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      pix_stb_q     <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_d_q       <= pix_d_d;
      arm_q         <= arm_d;
      upd_q         <= upd_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_stb_q     <= pix_stb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_stb     = pix_stb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line/enable/reset
// corners and a shrunken 16x11 instance (active-high hsync) for whole-frame checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_clk_in = 1'b0;
  logic en = 1'b1;

  logic       d_pix_stb, d_hsync, d_vsync, d_active, d_line_start, d_frame_start;
  logic [9:0] d_x, d_y;
  logic       s_pix_stb, s_hsync, s_vsync, s_active, s_line_start, s_frame_start;
  logic [3:0] s_x, s_y;

  int n_vec = 0;
  int n_bad = 0;
  int s     = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .rst(rst), .pix_clk_in(pix_clk_in), .en(en),
    .pix_stb(d_pix_stb), .hsync(d_hsync), .vsync(d_vsync), .active(d_active),
    .x(d_x), .y(d_y), .line_start(d_line_start), .frame_start(d_frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b0), .XW(4), .YW(4)
  ) u_small (
    .clk(clk), .rst(rst), .pix_clk_in(pix_clk_in), .en(en),
    .pix_stb(s_pix_stb), .hsync(s_hsync), .vsync(s_vsync), .active(s_active),
    .x(s_x), .y(s_y), .line_start(s_line_start), .frame_start(s_frame_start)
  );

  typedef struct {
    int s;
    int x;
    int y;
    bit hs;
    bit vs;
    bit act;
    bit ls;
    bit fs;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rise();
    pix_clk_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic fall();
    pix_clk_in = 1'b0;
    tick();
    chk("stb_one_cycle", d_pix_stb, 0);
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stb"},  d_pix_stb, 0);
    chk({tag, "_x"},    d_x, 0);
    chk({tag, "_y"},    d_y, 0);
    chk({tag, "_act"},  d_active, 0);
    chk({tag, "_hs"},   d_hsync, 1);
    chk({tag, "_vs"},   d_vsync, 1);
    chk({tag, "_ls"},   d_line_start, 0);
    chk({tag, "_fs"},   d_frame_start, 0);
    chk({tag, "_s_hs"}, s_hsync, 0);
    chk({tag, "_s_vs"}, s_vsync, 1);
  endtask

  task automatic chk_small(input int k);
    int sx, sy;
    sx = (k - 1) % 16;
    sy = (k - 1) / 16;
    chk("sm_stb", s_pix_stb, 1);
    chk("sm_x",   s_x, sx);
    chk("sm_y",   s_y, sy);
    chk("sm_hs",  s_hsync, (sx >= 10 && sx <= 12) ? 1 : 0);
    chk("sm_vs",  s_vsync, (sy == 7 || sy == 8) ? 0 : 1);
    chk("sm_act", s_active, (sx < 8 && sy < 6) ? 1 : 0);
    chk("sm_ls",  s_line_start, (sx == 0) ? 1 : 0);
    chk("sm_fs",  s_frame_start, (k == 1) ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hs_bad;
    int err;

    //        s    x    y  hs vs act ls fs
    tbl[0]  = '{1,    0,   0, 1, 1, 1, 1, 1};
    tbl[1]  = '{640,  639, 0, 1, 1, 1, 0, 0};
    tbl[2]  = '{641,  640, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{656,  655, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{657,  656, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{752,  751, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{753,  752, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{800,  799, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{801,  0,   1, 1, 1, 1, 1, 0};
    tbl[9]  = '{802,  1,   1, 1, 1, 1, 0, 0};
    tbl[10] = '{901,  100, 1, 1, 1, 1, 0, 0};

    tick();
    tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    hs_bad = 0;
    for (int i = 0; i < 11; i++) begin
      while (s < tbl[i].s) begin
        if (s > 0) fall();
        rise();
        s++;
        if (s <= 800 && d_hsync !== ((d_x >= 656 && d_x <= 751) ? 1'b0 : 1'b1)) hs_bad++;
      end
      chk($sformatf("v%0d_stb", i), d_pix_stb, 1);
      chk($sformatf("v%0d_x", i),   d_x, tbl[i].x);
      chk($sformatf("v%0d_y", i),   d_y, tbl[i].y);
      chk($sformatf("v%0d_hs", i),  d_hsync, tbl[i].hs);
      chk($sformatf("v%0d_vs", i),  d_vsync, tbl[i].vs);
      chk($sformatf("v%0d_act", i), d_active, tbl[i].act);
      chk($sformatf("v%0d_ls", i),  d_line_start, tbl[i].ls);
      chk($sformatf("v%0d_fs", i),  d_frame_start, tbl[i].fs);
    end
    chk("hsync_window_line0", hs_bad, 0);
    fall();

    // Enable low for 20 clk while pix_clk keeps toggling: no pulses, position held.
    en = 1'b0;
    err = 0;
    for (int k = 0; k < 20; k++) begin
      pix_clk_in = ((k % 4) < 2);
      tick();
      if (d_pix_stb || d_line_start || d_frame_start) err++;
    end
    chk("en_low_pulses", err, 0);
    chk("en_low_x", d_x, 100);
    chk("en_low_y", d_y, 1);
    en = 1'b1;
    rise();
    s++;
    chk("en_resume_stb", d_pix_stb, 1);
    chk("en_resume_x", d_x, 101);
    chk("en_resume_y", d_y, 1);
    fall();

    while (s < 1101) begin
      rise();
      s++;
      if (s < 1101) fall();
    end
    chk("pre_rst_x", d_x, 300);
    chk("pre_rst_y", d_y, 1);
    chk("pre_rst_act", d_active, 1);
    fall();

    // Asynchronous reset mid-cycle, with pix_clk_in held high through release.
    #2;
    rst = 1'b1;
    pix_clk_in = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    tick();
    rst = 1'b0;
    err = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_pix_stb || s_pix_stb) err++;
    end
    chk("held_high_no_stb", err, 0);
    pix_clk_in = 1'b0;
    tick();
    tick();
    rise();
    s = 1;
    chk("post_rst_stb", d_pix_stb, 1);
    chk("post_rst_x",   d_x, 0);
    chk("post_rst_y",   d_y, 0);
    chk("post_rst_act", d_active, 1);
    chk("post_rst_ls",  d_line_start, 1);
    chk("post_rst_fs",  d_frame_start, 1);

    // Whole frame on the small instance, then the wrap back to (0,0).
    while (s <= 176) begin
      chk_small(s);
      fall();
      rise();
      s++;
    end
    chk("sm_wrap_stb", s_pix_stb, 1);
    chk("sm_wrap_x",   s_x, 0);
    chk("sm_wrap_y",   s_y, 0);
    chk("sm_wrap_fs",  s_frame_start, 1);
    chk("sm_wrap_ls",  s_line_start, 1);
    chk("sm_wrap_act", s_active, 1);
    fall();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Downstream stage of the VGA clock divider. Consumes the divider's toggling divided-clock level and generates the horizontal/vertical raster timing for the VGA output path.
- Entirely synchronous to the system clock: it edge-detects the divided clock into a one-cycle pixel strobe and never clocks logic from the divided signal.
- Outputs are hsync, vsync, the active-video flag, raster coordinates, and line/frame start pulses, all consumed by the pixel/colour stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- XW, 10, x coordinate width; must hold H_TOTAL-1
- YW, 10, y coordinate width; must hold V_TOTAL-1

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- pix_clk_in  in  1  divided-clock level from the divider, synchronous to clk
- en  in  1  run enable; when low, the raster freezes
- pix_stb  out  1  registered one-cycle pulse; outputs changed this cycle
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  high in the visible region
- x  out  XW  current horizontal count
- y  out  YW  current vertical count
- line_start  out  1  one-cycle pulse when h becomes 0
- frame_start  out  1  one-cycle pulse when (h,v) becomes (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800 by default); V_TOTAL likewise (525 by default).
- Reset is asynchronous and active-high, and takes effect immediately, including mid-line and mid-frame:
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so the first strobe lands on (0,0)
  - pix_d = 0, arm = 0
  - pix_stb = 0, line_start = 0, frame_start = 0, active = 0, x = 0, y = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
- Edge detect:
  - pix_d <= pix_clk_in every clk
  - arm <= 1 on the first clk after reset
  - internal stb = arm & pix_clk_in & ~pix_d & en
  - arm suppresses a false edge when pix_clk_in is already high as reset releases
- Counters advance only on stb:
  - h_cnt wraps H_TOTAL-1 -> 0
  - v_cnt increments only when h_cnt wraps; v_cnt wraps V_TOTAL-1 -> 0
  - no other state changes on non-stb cycles
- Latency: on the stb cycle the counters update. On the next clk edge all outputs register the decode of the new counter values, and pix_stb = 1 for that one cycle.
- Decode:
  - x = h_cnt, y = v_cnt, always raw (not clamped outside the visible region)
  - active = (h < H_ACTIVE) & (v < V_ACTIVE)
  - hsync = HS_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vsync likewise on v
  - line_start = 1 for the one cycle that reflects a new h == 0
  - frame_start = 1 for the one cycle that reflects a new (0,0)
  - all pulses coincide with pix_stb
- en low:
  - stb is masked; counters and all level outputs hold
  - pix_stb, line_start and frame_start stay 0
  - pix_d keeps sampling, so an edge during en = 0 is discarded, not deferred
  - re-asserting en resumes from the held position
- Strobe rate: valid for pix_clk_in toggling no faster than every clk (max one strobe per 2 clk). Counter correctness does not depend on the divide ratio.

Test Plan:
- Reset, with pix_clk_in toggling every 2 clk (strobe every 4 clk) and en = 1 -> first pix_stb carries x = 0, y = 0, active = 1, line_start = 1, frame_start = 1, hsync = vsync = 1.
- Run one line -> hsync = 0 exactly for x = 656..751 (96 strobes); active falls at x = 640; at x = 799 -> 0, y increments and line_start pulses.
- Run a full frame -> vsync = 0 only for y = 490..491; active = 0 for y >= 480; after 800*525 = 420000 strobes frame_start pulses again at (0,0).
- Hold pix_clk_in = 1 through reset release -> no pix_stb until the next 0->1 transition.
- Drop en for 20 clk at x = 100 -> x holds at 100 with no pulses; after en rises, the next strobe gives x = 101.
- Assert rst for 1 clk mid-frame at (x = 300, y = 200) -> outputs return to reset values immediately; the next strobe yields (0,0) with frame_start = 1.
